// File: rtl/patch_embed_pingpong.sv
// patch_embed_pingpong: packs fmap/patch spike lanes into 2-bit sums and buffers frames in ping-pong banks
module patch_embed_pingpong #(
  parameter int LANES = 32,
  parameter int DEPTH = 4096,
  parameter int ADDR_W = 12,
  localparam int DW = 2 * LANES
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic [LANES-1:0]  i_fmap,
  input  logic [LANES-1:0]  i_patchdata,
  input  logic              i_last,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DW-1:0]     o_rd_data,
  output logic              o_rd_valid,
  output logic              o_bank_ready,
  output logic [ADDR_W:0]   o_rd_len,
  input  logic              i_rd_release,
  output logic              o_frame_trunc,
  input  logic              i_switch,
  input  logic              i_ext_bank,
  input  logic              i_ext_wea,
  input  logic [ADDR_W-1:0] i_ext_addra,
  input  logic [DW-1:0]     i_ext_dina,
  input  logic [ADDR_W-1:0] i_ext_addrb,
  output logic [DW-1:0]     o_ext_doutb
);
  logic [DW-1:0] mem [2][DEPTH];
  logic [DW-1:0] pack, pend_data, ram_q, wdata;
  logic [ADDR_W-1:0] wr_addr, waddr, raddr;
  logic [ADDR_W:0] len [2];
  logic [1:0] full;
  logic wr_bank, rd_bank, pend_v, pend_last, rd_v1;
  logic commit, frame_close, rel, we, wbank, rbank;
  for (genvar k = 0; k < LANES; k++) begin : g_pack
    assign pack[2*k+1:2*k] = {i_fmap[k] & i_patchdata[k], i_fmap[k] ^ i_patchdata[k]};
  end
  assign o_data_ready = !full[wr_bank] && !i_switch;
  // a registered word waits if its target bank is still full (close landed on a full bank)
  assign commit = pend_v && !full[wr_bank];
  assign frame_close = commit && (pend_last || wr_addr == ADDR_W'(DEPTH - 1));
  assign rel = i_rd_release && full[rd_bank] && !i_switch;
  assign we = commit || (i_switch && i_ext_wea);
  assign wbank = commit ? wr_bank : i_ext_bank;
  assign waddr = commit ? wr_addr : i_ext_addra;
  assign wdata = commit ? pend_data : i_ext_dina;
  assign rbank = i_switch ? i_ext_bank : rd_bank;
  assign raddr = i_switch ? i_ext_addrb : i_rd_addr;
  assign o_bank_ready = full[rd_bank];
  assign o_rd_len = len[rd_bank];
  assign o_ext_doutb = ram_q;
  always_ff @(posedge s_clk) begin
    if (we) mem[wbank][waddr] <= wdata;
    ram_q <= mem[rbank][raddr];
  end
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_addr <= '0;
      full <= '0;
      len <= '{default: '0};
      pend_v <= 1'b0;
      pend_last <= 1'b0;
      pend_data <= '0;
      rd_v1 <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data <= '0;
      o_frame_trunc <= 1'b0;
    end else begin
      if (i_data_valid && o_data_ready) begin
        pend_v <= 1'b1;
        pend_data <= pack;
        pend_last <= i_last;
      end else if (commit) pend_v <= 1'b0;
      o_frame_trunc <= frame_close && !pend_last;
      if (commit) wr_addr <= frame_close ? '0 : wr_addr + 1'b1;
      if (frame_close) begin
        full[wr_bank] <= 1'b1;
        len[wr_bank] <= {1'b0, wr_addr} + 1'b1;
        wr_bank <= !wr_bank;
      end
      if (rel) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= !rd_bank;
      end
      rd_v1 <= i_rd_en && !i_switch;
      o_rd_valid <= rd_v1 && !i_switch;
      if (rd_v1) o_rd_data <= ram_q;
    end
  end
endmodule
